// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters (VGA fetch, CPU data port) and the VRAM macro.
// The arbiter takes the slave view; the requester/RAM side takes the master view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [BE_W-1:0]   cpu_be;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vga_req, vga_addr,
        output vga_gnt, vga_rdata, vga_rvalid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_gnt, cpu_rdata, cpu_rvalid,
        output mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output vga_req, vga_addr,
        input  vga_gnt, vga_rdata, vga_rvalid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_gnt, cpu_rdata, cpu_rvalid,
        input  mem_addr, mem_we, mem_be, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scanout has priority, a wait counter lets a starving CPU win one cycle.
// Define VRAM_WBUF_EN to add a single-entry posted write buffer on the CPU path.
module vram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input logic           clk,
    input logic           reset_n,
    vram_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_CPU,
        OWN_BUF
    } owner_e;

    owner_e     owner;
    owner_e     rd_owner_q, rd_owner_d;
    logic [7:0] wait_q, wait_d;
    logic       starve;
    logic       cpu_pend;
    logic       cpu_gnt;

`ifdef VRAM_WBUF_EN
    logic              buf_full_q, buf_full_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [BE_W-1:0]   buf_be_q, buf_be_d;
    logic              buf_hit;
    logic              read_ok;
    logic              wr_gnt;
`endif

    assign starve = (wait_q >= 8'(STARVE_LIMIT));

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin : arbitrate
        owner   = OWN_NONE;
        cpu_gnt = 1'b0;
`ifdef VRAM_WBUF_EN
        // A read of the buffered address must wait for the drain, or it would see stale VRAM.
        buf_hit  = buf_full_q && (bus.cpu_addr == buf_addr_q);
        read_ok  = bus.cpu_req && !bus.cpu_we && !buf_hit;
        wr_gnt   = reset_n && bus.cpu_req && bus.cpu_we && !buf_full_q;
        cpu_pend = buf_full_q || read_ok;
        if (reset_n) begin
            if (starve && buf_full_q)  owner = OWN_BUF;
            else if (starve && read_ok) owner = OWN_CPU;
            else if (bus.vga_req)       owner = OWN_VGA;
            else if (buf_full_q)        owner = OWN_BUF;
            else if (read_ok)           owner = OWN_CPU;
        end
        cpu_gnt = (owner == OWN_CPU) || wr_gnt;
`else
        cpu_pend = bus.cpu_req;
        if (reset_n) begin
            if (starve && bus.cpu_req) owner = OWN_CPU;
            else if (bus.vga_req)      owner = OWN_VGA;
            else if (bus.cpu_req)      owner = OWN_CPU;
        end
        cpu_gnt = (owner == OWN_CPU);
`endif
    end

    always_comb begin : next_state
        wait_d = wait_q;
        if (!cpu_pend || owner == OWN_CPU || owner == OWN_BUF) begin
            wait_d = '0;
        end else if (wait_q != 8'hFF) begin
            wait_d = wait_q + 8'd1;
        end

        rd_owner_d = OWN_NONE;
        if (owner == OWN_VGA || (owner == OWN_CPU && !bus.cpu_we)) begin
            rd_owner_d = owner;
        end

`ifdef VRAM_WBUF_EN
        buf_full_d = buf_full_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_be_d   = buf_be_q;
        if (owner == OWN_BUF) begin
            buf_full_d = 1'b0;
        end
        if (wr_gnt) begin
            buf_full_d = 1'b1;
            buf_addr_d = bus.cpu_addr;
            buf_data_d = bus.cpu_wdata;
            buf_be_d   = bus.cpu_be;
        end
`endif
    end

    always_comb begin : port_mux
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        case (owner)
            OWN_VGA: begin
                bus.mem_addr = bus.vga_addr;
            end
            OWN_CPU: begin
                bus.mem_addr = bus.cpu_addr;
                if (bus.cpu_we) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_be    = bus.cpu_be;
                    bus.mem_wdata = bus.cpu_wdata;
                end
            end
`ifdef VRAM_WBUF_EN
            OWN_BUF: begin
                bus.mem_addr  = buf_addr_q;
                bus.mem_we    = 1'b1;
                bus.mem_be    = buf_be_q;
                bus.mem_wdata = buf_data_q;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_owner_q <= OWN_NONE;
            wait_q     <= '0;
`ifdef VRAM_WBUF_EN
            buf_full_q <= 1'b0;
`endif
        end else begin
            rd_owner_q <= rd_owner_d;
            wait_q     <= wait_d;
`ifdef VRAM_WBUF_EN
            buf_full_q <= buf_full_d;
`endif
        end
    end

`ifdef VRAM_WBUF_EN
    // NOTE: the buffer payload is deliberately left unreset; buf_full_q alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        buf_addr_q <= buf_addr_d;
        buf_data_q <= buf_data_d;
        buf_be_q   <= buf_be_d;
    end
`endif

    // Gating with reset_n drops a read return that is in flight when reset arrives.
    assign bus.vga_gnt    = (owner == OWN_VGA);
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.vga_rvalid = reset_n && (rd_owner_q == OWN_VGA);
    assign bus.cpu_rvalid = reset_n && (rd_owner_q == OWN_CPU);
    assign bus.vga_rdata  = bus.vga_rvalid ? bus.mem_rdata : '0;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expected read data, a monitor pops on rvalid.
// Covers the posted-write-buffer variant when VRAM_WBUF_EN is defined.
module tb_vram_arbiter;
    logic clk;
    logic reset_n;
    logic mem_load;

    vram_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();

    vram_arbiter #(
        .ADDR_W      (13),
        .DATA_W      (32),
        .STARVE_LIMIT(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks;
    int n_errors;
    logic [31:0] vga_q[$];
    logic [31:0] cpu_q[$];

    logic [31:0] vram[0:511];
    logic [31:0] mem_rdata_q;
    logic [8:0]  mem_idx;

    assign mem_idx       = bus.mem_addr[8:0];
    assign bus.mem_rdata = mem_rdata_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, read latency 1, byte-enabled writes.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 512; i++) vram[i] <= 32'h0;
            vram[0]   <= 32'hA0;
            vram[1]   <= 32'hA1;
            vram[2]   <= 32'hA2;
            vram[3]   <= 32'hA3;
            vram[256] <= 32'hC0DE0100;
        end else if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) vram[mem_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
        mem_rdata_q <= vram[mem_idx];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // VGA only ever fetches addresses 0..3, which hold 0xA0..0xA3.
    always @(negedge clk) begin
        if (bus.vga_gnt) vga_q.push_back(32'hA0 + 32'(bus.vga_addr));
    end

    always @(negedge clk) begin
        if (bus.vga_rvalid) begin
            if (vga_q.size() == 0) check("vga_unexpected_rvalid", 32'd1, 32'd0);
            else check("vga_rdata", bus.vga_rdata, vga_q.pop_front());
        end
        if (bus.cpu_rvalid) begin
            if (cpu_q.size() == 0) check("cpu_unexpected_rvalid", 32'd1, 32'd0);
            else check("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a CPU request and returns at the negedge of the granting cycle (request still held).
    task automatic cpu_access(input logic we, input logic [12:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] exp, input int max_wait,
                              output int waited);
        logic granted;
        granted       = 1'b0;
        waited        = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_be    = be;
        while (!granted && waited <= max_wait) begin
            @(negedge clk);
            if (bus.cpu_gnt) begin
                granted = 1'b1;
                if (!we) cpu_q.push_back(exp);
            end else begin
                waited++;
                if (waited <= max_wait) step();
            end
        end
        check("cpu_gnt_within_budget", 32'(granted), 32'd1);
    endtask

    task automatic cpu_release();
        step();
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    task automatic vga_burst();
        for (int i = 0; i < 4; i++) begin
            bus.vga_req  = 1'b1;
            bus.vga_addr = 13'(i);
            @(negedge clk);
            check($sformatf("burst_vga_gnt_%0d", i), 32'(bus.vga_gnt), 32'd1);
            check($sformatf("burst_mem_addr_%0d", i), 32'(bus.mem_addr), 32'(i));
            check($sformatf("burst_mem_we_%0d", i), 32'(bus.mem_we), 32'd0);
            step();
        end
        bus.vga_req = 1'b0;
    endtask

    int waited;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        mem_load      = 1'b1;
        reset_n       = 1'b0;
        bus.vga_req   = 1'b1;
        bus.vga_addr  = '0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 13'h5;
        bus.cpu_wdata = 32'hFFFF_FFFF;
        bus.cpu_be    = 4'hF;

        // Reset held with both requesters active.
        repeat (3) begin
            @(negedge clk);
            check("rst_vga_gnt", 32'(bus.vga_gnt), 32'd0);
            check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
            check("rst_rvalids", 32'({bus.vga_rvalid, bus.cpu_rvalid}), 32'd0);
            check("rst_mem_we_be", 32'({bus.mem_we, bus.mem_be}), 32'd0);
            check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        end
        step();
        bus.vga_req = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        mem_load    = 1'b0;
        reset_n     = 1'b1;
        step();

        // VGA-only burst, addresses 0..3.
        vga_burst();
        step();

        // Partial CPU write then read back.
        cpu_access(1'b1, 13'h5, 32'hDEADBEEF, 4'b0011, 32'h0, 0, waited);
`ifdef VRAM_WBUF_EN
        cpu_release();
        @(negedge clk);
`endif
        check("wr_mem_we", 32'(bus.mem_we), 32'd1);
        check("wr_mem_be", 32'(bus.mem_be), 32'h3);
        check("wr_mem_addr", 32'(bus.mem_addr), 32'h5);
        check("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
`ifdef VRAM_WBUF_EN
        step();
`else
        cpu_release();
`endif
        cpu_access(1'b0, 13'h5, 32'h0, 4'h0, 32'h0000BEEF, 0, waited);
        check("rd_mem_be_zero", 32'({bus.mem_we, bus.mem_be}), 32'd0);
        cpu_release();
        step();

        // Contention: CPU wins on the 9th cycle only.
        bus.vga_req  = 1'b1;
        bus.vga_addr = 13'h2;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 13'h100;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("contend_vga_gnt_c%0d", c), 32'(bus.vga_gnt), 32'(c != 9));
            check($sformatf("contend_cpu_gnt_c%0d", c), 32'(bus.cpu_gnt), 32'(c == 9));
            if (bus.cpu_gnt) cpu_q.push_back(32'hC0DE0100);
            step();
            if (c == 9) bus.cpu_req = 1'b0;
        end
        bus.vga_req = 1'b0;
        step();

`ifdef VRAM_WBUF_EN
        // Posted write while VGA streams; second write and hazard read stall until drain.
        bus.vga_req  = 1'b1;
        bus.vga_addr = 13'h1;
        cpu_access(1'b1, 13'h10, 32'h12345678, 4'hF, 32'h0, 0, waited);
        cpu_release();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 13'h11;
        bus.cpu_wdata = 32'h55;
        @(negedge clk);
        check("wbuf_second_write_stall", 32'(bus.cpu_gnt), 32'd0);
        cpu_release();
        cpu_access(1'b0, 13'h10, 32'h0, 4'h0, 32'h12345678, 40, waited);
        check("wbuf_read_wait_cycles", 32'(waited), 32'd16);
        cpu_release();
        bus.vga_req = 1'b0;
        step();
`endif

        // Reset one cycle after a CPU read grant: the return must be dropped.
        cpu_access(1'b0, 13'h3, 32'h0, 4'h0, 32'h0, 0, waited);
        void'(cpu_q.pop_back());
        step();
        bus.cpu_req = 1'b0;
        reset_n     = 1'b0;
        @(negedge clk);
        check("rst_mid_read_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        step();
        @(negedge clk);
        check("rst_mid_read_rvalid_2", 32'(bus.cpu_rvalid), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        vga_burst();

        repeat (3) step();
        check("vga_queue_drained", 32'(vga_q.size()), 32'd0);
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
